// File: rtl/jtpinpon_objscan.sv
// -----------------------------------------------------------------------------
// jtpinpon_objscan
// Object-table scanner for the Ping Pong object line drawer. Once per scan line
// it walks the object RAM from index OBJMAX-1 down to 0. Every object whose
// 16-line band covers vrender is handed to the drawer through a draw/busy
// handshake. Object 0 is visited last, so it wins in the overwrite buffer.
//
// Object entry layout (4 bytes):
//   byte0 = ypos, byte1 = code, byte2 = {vflip, hflip, 1'b0, pal[4:0]}, byte3 = xpos
//
// Ports
//   clk, rst          system clock, asynchronous active-high reset
//   cen2              scan clock enable; all state changes happen on cen2
//   hinit_x           line start pulse; starts or restarts a scan
//   vrender[7:0]      line being prepared
//   oram_addr         object RAM address {index, byte[1:0]}
//   oram_dout[7:0]    object RAM data, one cen2 of read latency
//   draw / busy       request to / status from the drawer
//   xpos, ysub, pal,
//   hflip, vflip,
//   code              object data for the drawer, stable while draw is high
//   done              high once the scan for the current line has finished
//   ovf               (JTPINPON_OBJ_LIMIT_EN only) hit limit reached this line
//
// Build option
//   JTPINPON_OBJ_LIMIT_EN: adds parameter LINEMAX and output ovf. The hit that
//   would be number LINEMAX+1 on a line is not drawn; instead ovf is set and
//   the scan ends.
// -----------------------------------------------------------------------------
module jtpinpon_objscan #(
  parameter int OBJMAX = 32,
  parameter int OBJ_AW = 7
`ifdef JTPINPON_OBJ_LIMIT_EN
  ,
  parameter int LINEMAX = 8
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cen2,
  input  logic              hinit_x,
  input  logic [7:0]        vrender,
  output logic [OBJ_AW-1:0] oram_addr,
  input  logic [7:0]        oram_dout,
  output logic              draw,
  input  logic              busy,
  output logic [7:0]        xpos,
  output logic [3:0]        ysub,
  output logic [4:0]        pal,
  output logic              hflip,
  output logic              vflip,
  output logic [7:0]        code,
`ifdef JTPINPON_OBJ_LIMIT_EN
  output logic              ovf,
`endif
  output logic              done
);

  localparam int IW = OBJ_AW - 2;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CHECK,
    DRAW,
    NEXT
  } state_t;

  state_t        st;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_dec;
  logic [2:0]    rd_cnt;     // byte being addressed; byte rd_cnt-1 is latched
  logic [7:0]    ypos_r;
  logic [7:0]    code_r;
  logic [6:0]    attr_r;     // {vflip, hflip, pal}; the spare bit is dropped
  logic [7:0]    xpos_r;
  logic [7:0]    ydiff;
  logic          hit;
  logic          limit_hit;

  assign idx_dec = idx - IW'(1);
  assign ydiff   = vrender - ypos_r;   // modulo 256 makes the band wrap at 0xFF
  assign hit     = (ydiff[7:4] == 4'd0);

  // The RAM address is decoded from registered state only, so it is glitch
  // free. While an object is checked or drawn, byte0 and byte1 of the next
  // lower index are already requested; NEXT then latches byte0 and the fresh
  // READ pass only has bytes 1..3 left. This keeps a missed object at five
  // cen2 cycles and lets RAM reads overlap the drawer.
  // NOTE: every signal driven from always_comb gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    oram_addr = {idx, 2'd0};
    case (st)
      READ:        oram_addr = {idx, rd_cnt[1:0]};
      CHECK, DRAW: oram_addr = {idx_dec, 2'd0};
      NEXT:        oram_addr = {idx_dec, 2'd1};
      default:     ;
    endcase
  end

`ifdef JTPINPON_OBJ_LIMIT_EN
  localparam int HCW = $clog2(LINEMAX + 1);

  logic [HCW-1:0] hit_cnt;

  assign limit_hit = (hit_cnt == HCW'(LINEMAX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt <= '0;
      ovf     <= 1'b0;
    end else if (cen2) begin
      if (hinit_x) begin
        hit_cnt <= '0;
        ovf     <= 1'b0;
      end else if (st == CHECK && hit) begin
        if (limit_hit) ovf <= 1'b1;
        else           hit_cnt <= hit_cnt + HCW'(1);
      end
    end
  end
`else
  assign limit_hit = 1'b0;
`endif

  // NOTE: state registers use non-blocking assignments so every register in
  // this block sees the pre-edge value of every other one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st     <= IDLE;
      idx    <= '0;
      rd_cnt <= 3'd0;
      ypos_r <= 8'd0;
      code_r <= 8'd0;
      attr_r <= 7'd0;
      xpos_r <= 8'd0;
      draw   <= 1'b0;
      xpos   <= 8'd0;
      ysub   <= 4'd0;
      pal    <= 5'd0;
      hflip  <= 1'b0;
      vflip  <= 1'b0;
      code   <= 8'd0;
      done   <= 1'b0;
    end else if (cen2) begin
      if (hinit_x) begin
        // A new line wins over anything in flight. The drawer is left alone;
        // a pending request is simply withdrawn.
        st     <= READ;
        idx    <= IW'(OBJMAX - 1);
        rd_cnt <= 3'd0;
        draw   <= 1'b0;
        done   <= 1'b0;
      end else begin
        case (st)
          IDLE: ;

          READ: begin
            case (rd_cnt)
              3'd1:    ypos_r <= oram_dout;
              3'd2:    code_r <= oram_dout;
              3'd3:    attr_r <= {oram_dout[7:6], oram_dout[4:0]};
              3'd4:    xpos_r <= oram_dout;
              default: ;
            endcase
            if (rd_cnt == 3'd4) st <= CHECK;
            else                rd_cnt <= rd_cnt + 3'd1;
          end

          CHECK: begin
            if (hit && limit_hit) begin
              done <= 1'b1;
              st   <= IDLE;
            end else if (hit) begin
              xpos  <= xpos_r;
              ysub  <= ydiff[3:0];
              pal   <= attr_r[4:0];
              hflip <= attr_r[5];
              vflip <= attr_r[6];
              code  <= code_r;
              st    <= DRAW;
            end else begin
              st <= NEXT;
            end
          end

          DRAW: begin
            // Request only once the drawer is free, then withdraw as soon as
            // it reports busy: one request per hit.
            if (!draw) begin
              if (!busy) draw <= 1'b1;
            end else if (busy) begin
              draw <= 1'b0;
              st   <= NEXT;
            end
          end

          NEXT: begin
            if (idx == '0) begin
              done <= 1'b1;
              st   <= IDLE;
            end else begin
              idx    <= idx_dec;
              ypos_r <= oram_dout;   // byte0 requested during CHECK/DRAW
              rd_cnt <= 3'd2;
              st     <= READ;
            end
          end

          default: st <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jtpinpon_objscan.sv
// -----------------------------------------------------------------------------
// tb_jtpinpon_objscan
// Self-checking bench for jtpinpon_objscan. Provides a synchronous object RAM
// (one cen2 of latency) and a drawer model that accepts a request when idle
// and stays busy for BUSY_LEN cen2 cycles. A table of single-object scans is
// applied in a loop; multi-object, restart and reset cases are written out.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_jtpinpon_objscan;

  localparam int OBJMAX   = 32;
  localparam int OBJ_AW   = 7;
  localparam int BUSY_LEN = 20;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cen2 = 1'b0;
  logic              hinit_x = 1'b0;
  logic [7:0]        vrender = 8'd0;
  logic [OBJ_AW-1:0] oram_addr;
  logic [7:0]        oram_dout = 8'd0;
  logic              draw;
  logic              busy;
  logic [7:0]        xpos;
  logic [3:0]        ysub;
  logic [4:0]        pal;
  logic              hflip;
  logic              vflip;
  logic [7:0]        code;
  logic              done;
`ifdef JTPINPON_OBJ_LIMIT_EN
  logic              ovf;
`endif

  jtpinpon_objscan #(.OBJMAX(OBJMAX), .OBJ_AW(OBJ_AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .cen2     (cen2),
    .hinit_x  (hinit_x),
    .vrender  (vrender),
    .oram_addr(oram_addr),
    .oram_dout(oram_dout),
    .draw     (draw),
    .busy     (busy),
    .xpos     (xpos),
    .ysub     (ysub),
    .pal      (pal),
    .hflip    (hflip),
    .vflip    (vflip),
    .code     (code),
`ifdef JTPINPON_OBJ_LIMIT_EN
    .ovf      (ovf),
`endif
    .done     (done)
  );

  always #5 clk = ~clk;
  always @(negedge clk) cen2 <= ~cen2;

  // Object RAM
  logic [7:0] mem [0:4*OBJMAX-1];
  always @(posedge clk) if (cen2) oram_dout <= mem[oram_addr];

  // Drawer model
  typedef struct packed {
    logic [7:0] xpos;
    logic [3:0] ysub;
    logic [4:0] pal;
    logic       hflip;
    logic       vflip;
    logic [7:0] code;
  } obj_t;

  obj_t draws[$];
  int   accept_t[$];
  bit   drawer_en = 1'b1;
  int   busy_cnt;
  int   cen_cnt;
  int   hs_err;     // draw rose while busy, or draw held >1 cen2 after busy
  int   both_cnt;
  logic draw_q;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= 1'b0;
      busy_cnt <= 0;
      draw_q   <= 1'b0;
      both_cnt <= 0;
    end else if (cen2) begin
      cen_cnt <= cen_cnt + 1;
      draw_q  <= draw;
      if (draw && !draw_q && busy) hs_err <= hs_err + 1;
      if (draw && busy) begin
        both_cnt <= both_cnt + 1;
        if (both_cnt >= 1) hs_err <= hs_err + 1;
      end else begin
        both_cnt <= 0;
      end
      if (busy) begin
        if (busy_cnt <= 1) busy <= 1'b0;
        busy_cnt <= busy_cnt - 1;
      end else if (draw && drawer_en) begin
        busy     <= 1'b1;
        busy_cnt <= BUSY_LEN;
        draws.push_back('{xpos, ysub, pal, hflip, vflip, code});
        accept_t.push_back(cen_cnt);
      end
    end
  end

  initial begin
    hs_err  = 0;
    cen_cnt = 0;
  end

  // Checking
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    do @(posedge clk); while (!cen2);
    #1;
  endtask

  task automatic fill_bg();
    for (int i = 0; i < OBJMAX; i++) begin
      mem[4*i]   = 8'hF0;
      mem[4*i+1] = 8'h00;
      mem[4*i+2] = 8'h00;
      mem[4*i+3] = 8'h00;
    end
  endtask

  task automatic put(input int i, input logic [7:0] b0, input logic [7:0] b1,
                     input logic [7:0] b2, input logic [7:0] b3);
    mem[4*i]   = b0;
    mem[4*i+1] = b1;
    mem[4*i+2] = b2;
    mem[4*i+3] = b3;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin tick(); n++; end
    check("drawer_idle", {31'd0, busy}, 32'd0);
  endtask

  task automatic pulse_hinit(input logic [7:0] vr);
    vrender = vr;
    hinit_x = 1'b1;
    tick();
    hinit_x = 1'b0;
  endtask

  task automatic run_scan(input logic [7:0] vr, input int budget, output int cyc);
    pulse_hinit(vr);
    check("done_clear", {31'd0, done}, 32'd0);
    cyc = 0;
    while (!done && cyc < budget) begin tick(); cyc++; end
    check("done_set", {31'd0, done}, 32'd1);
  endtask

  task automatic wait_draw(input string name);
    int n = 0;
    while (!draw && n < 200) begin tick(); n++; end
    check(name, {31'd0, draw}, 32'd1);
  endtask

  // Single-object scan table
  typedef struct {
    string      name;
    int         idx;      // -1: background only
    logic [7:0] b0, b1, b2, b3;
    logic [7:0] vr;
    int         ndraw;
    logic [3:0] ysub;
    logic [4:0] pal;
    logic       hf, vf;
    logic [7:0] code, xpos;
    int         budget;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int   cyc, base, gap;
    obj_t got;

    vecs[0] = '{"all_miss",   -1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h20, 0, 4'h0, 5'h00, 1'b0, 1'b0, 8'h00, 8'h00, 192};
    vecs[1] = '{"entry5",      5, 8'h1C, 8'h3A, 8'hC7, 8'h40, 8'h20, 1, 4'h4, 5'h07, 1'b1, 1'b1, 8'h3A, 8'h40, 400};
    vecs[2] = '{"ywrap",       0, 8'hF8, 8'h11, 8'h25, 8'h99, 8'h03, 1, 4'hB, 5'h05, 1'b0, 1'b0, 8'h11, 8'h99, 400};
    vecs[3] = '{"band_last",  31, 8'h20, 8'hFF, 8'h5F, 8'h00, 8'h2F, 1, 4'hF, 5'h1F, 1'b1, 1'b0, 8'hFF, 8'h00, 400};
    vecs[4] = '{"band_past",  12, 8'h20, 8'hAA, 8'h00, 8'h10, 8'h30, 0, 4'h0, 5'h00, 1'b0, 1'b0, 8'h00, 8'h00, 400};
    vecs[5] = '{"band_before", 7, 8'h20, 8'hAA, 8'h00, 8'h10, 8'h1F, 0, 4'h0, 5'h00, 1'b0, 1'b0, 8'h00, 8'h00, 400};
    vecs[6] = '{"hflip_only", 17, 8'h20, 8'h5C, 8'h41, 8'hE0, 8'h20, 1, 4'h0, 5'h01, 1'b1, 1'b0, 8'h5C, 8'hE0, 400};

    fill_bg();

    // Reset state
    repeat (4) @(posedge clk);
    #1;
    check("reset_outputs", {7'd0, oram_addr, draw, xpos, ysub, pal, hflip, vflip, code, done}, 32'd0);
    rst = 1'b0;
    repeat (5) tick();
    check("idle_no_draw", {31'd0, draw}, 32'd0);
    check("idle_done", {31'd0, done}, 32'd0);

    // Table of single-object scans
    for (int v = 0; v < 7; v++) begin
      fill_bg();
      if (vecs[v].idx >= 0) put(vecs[v].idx, vecs[v].b0, vecs[v].b1, vecs[v].b2, vecs[v].b3);
      wait_idle();
      base = draws.size();
      run_scan(vecs[v].vr, vecs[v].budget, cyc);
      check($sformatf("%s.ndraw", vecs[v].name), draws.size() - base, vecs[v].ndraw);
      if (vecs[v].ndraw == 1 && draws.size() > base) begin
        got = draws[base];
        check($sformatf("%s.xpos", vecs[v].name), {24'd0, got.xpos}, {24'd0, vecs[v].xpos});
        check($sformatf("%s.ysub", vecs[v].name), {28'd0, got.ysub}, {28'd0, vecs[v].ysub});
        check($sformatf("%s.pal", vecs[v].name), {27'd0, got.pal}, {27'd0, vecs[v].pal});
        check($sformatf("%s.hflip", vecs[v].name), {31'd0, got.hflip}, {31'd0, vecs[v].hf});
        check($sformatf("%s.vflip", vecs[v].name), {31'd0, got.vflip}, {31'd0, vecs[v].vf});
        check($sformatf("%s.code", vecs[v].name), {24'd0, got.code}, {24'd0, vecs[v].code});
      end
    end

    // Entries 9 and 2 hit: drawn in order 9 then 2
    fill_bg();
    put(9, 8'h18, 8'h09, 8'h01, 8'h90);
    put(2, 8'h1A, 8'h02, 8'h82, 8'h20);
    wait_idle();
    base = draws.size();
    run_scan(8'h20, 2000, cyc);
    check("two_hit.ndraw", draws.size() - base, 2);
    if (draws.size() >= base + 2) begin
      check("two_hit.first_code", {24'd0, draws[base].code}, 32'h09);
      check("two_hit.first_ysub", {28'd0, draws[base].ysub}, 32'h8);
      check("two_hit.second_code", {24'd0, draws[base+1].code}, 32'h02);
      check("two_hit.second_ysub", {28'd0, draws[base+1].ysub}, 32'h6);
      check("two_hit.second_vflip", {31'd0, draws[base+1].vflip}, 32'd1);
      check("two_hit.second_pal", {27'd0, draws[base+1].pal}, 32'd2);
    end

    // Adjacent hits 3 and 2: second request must wait for busy to fall
    fill_bg();
    put(3, 8'h20, 8'h33, 8'h00, 8'h00);
    put(2, 8'h20, 8'h22, 8'h00, 8'h00);
    wait_idle();
    base = draws.size();
    run_scan(8'h25, 2000, cyc);
    check("adjacent.ndraw", draws.size() - base, 2);
    if (draws.size() >= base + 2) begin
      check("adjacent.order", {16'd0, draws[base].code, draws[base+1].code}, 32'h3322);
      gap = accept_t[base+1] - accept_t[base];
      check("adjacent.after_busy", {31'd0, gap > BUSY_LEN}, 32'd1);
    end
    check("handshake_errors", hs_err, 0);

    // hinit_x while in DRAW: draw drops, scan restarts at index 31
    fill_bg();
    put(31, 8'h20, 8'h31, 8'h03, 8'h55);
    wait_idle();
    drawer_en = 1'b0;
    pulse_hinit(8'h20);
    wait_draw("restart.draw_up");
    check("restart.xpos", {24'd0, xpos}, 32'h55);
    tick();
    check("restart.draw_hold", {31'd0, draw}, 32'd1);
    pulse_hinit(8'h20);
    check("restart.draw_drop", {31'd0, draw}, 32'd0);
    check("restart.addr", {25'd0, oram_addr}, 32'd124);
    check("restart.done", {31'd0, done}, 32'd0);
    drawer_en = 1'b1;
    base = draws.size();
    cyc = 0;
    while (!done && cyc < 2000) begin tick(); cyc++; end
    check("restart.done_set", {31'd0, done}, 32'd1);
    check("restart.ndraw", draws.size() - base, 1);
    if (draws.size() > base) check("restart.code", {24'd0, draws[base].code}, 32'h31);

    // Reset asserted mid-scan while drawing
    fill_bg();
    put(16, 8'h20, 8'h7E, 8'hDF, 8'hA5);
    wait_idle();
    drawer_en = 1'b0;
    pulse_hinit(8'h2A);
    wait_draw("midrst.draw_up");
    rst = 1'b1;
    #1;
    check("midrst.outputs", {7'd0, oram_addr, draw, xpos, ysub, pal, hflip, vflip, code, done}, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    drawer_en = 1'b1;
    repeat (6) tick();
    check("midrst.idle", {30'd0, draw, done}, 32'd0);

`ifdef JTPINPON_OBJ_LIMIT_EN
    // Twelve hits on one line: only the first eight are drawn
    fill_bg();
    for (int i = 0; i < 12; i++) put(i, 8'h20, 8'(i), 8'h00, 8'h00);
    wait_idle();
    base = draws.size();
    run_scan(8'h20, 3000, cyc);
    check("limit.ndraw", draws.size() - base, 8);
    check("limit.ovf", {31'd0, ovf}, 32'd1);
    if (draws.size() >= base + 8) begin
      check("limit.first_code", {24'd0, draws[base].code}, 32'd11);
      check("limit.last_code", {24'd0, draws[base+7].code}, 32'd4);
    end
    pulse_hinit(8'h20);
    check("limit.ovf_clear", {31'd0, ovf}, 32'd0);
    cyc = 0;
    while (!done && cyc < 3000) begin tick(); cyc++; end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish, limit 500us");
    $fatal(1, "watchdog");
  end

endmodule
